// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with blanking, PWM brightness
// and frame-synchronous double-buffered display word.
module seven_seg_scan_driver #(
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic [31:0] load_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);
    localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [27:0]   act_q, act_d;
    logic [27:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic          tick_q, tick_d;
    logic          rdy_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          slot_end;
    logic          accept;
    logic          lit;
    logic [3:0]    nib;
    logic [3:0]    en;
    logic [3:0]    dps;
    logic [6:0]    hex;

    assign load_ready = rdy_q && !pend_full_q;
    assign accept     = load_valid && load_ready;
    assign en         = act_q[23:20];
    assign dps        = act_q[19:16];

    always_comb begin
        slot_end    = (cnt_q == LAST);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
        tick_d      = slot_end && (idx_q == 2'd3);
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        // tick_q high marks the boundary cycle; a direct load only lands here
        if (tick_q && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            if (tick_q) begin
                act_d = load_data[27:0];
            end else begin
                pend_d      = load_data[27:0];
                pend_full_d = 1'b1;
            end
        end
    end

    always_comb begin
        nib = 4'h0;
        unique case (idx_q)
            2'd0: nib = act_q[3:0];
            2'd1: nib = act_q[7:4];
            2'd2: nib = act_q[11:8];
            2'd3: nib = act_q[15:12];
        endcase
        hex = 7'h00;
        unique case (nib)
            4'h0: hex = 7'h3F;
            4'h1: hex = 7'h06;
            4'h2: hex = 7'h5B;
            4'h3: hex = 7'h4F;
            4'h4: hex = 7'h66;
            4'h5: hex = 7'h6D;
            4'h6: hex = 7'h7D;
            4'h7: hex = 7'h07;
            4'h8: hex = 7'h7F;
            4'h9: hex = 7'h6F;
            4'hA: hex = 7'h77;
            4'hB: hex = 7'h7C;
            4'hC: hex = 7'h39;
            4'hD: hex = 7'h5E;
            4'hE: hex = 7'h79;
            4'hF: hex = 7'h71;
        endcase
        lit = (cnt_q >= BLK) && en[idx_q]
              && (cnt_q[3:0] <= act_q[27:24]);
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (lit) begin
            an_d  = (4'b0001 << idx_q) ^ AN_OFF;
            seg_d = hex ^ SEG_OFF;
            dp_d  = dps[idx_q] ^ DP_OFF;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            tick_q      <= 1'b0;
            rdy_q       <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            tick_q      <= tick_d;
            rdy_q       <= 1'b1;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a cycle-level reference
// model feeding an expected-output queue.
module tb_seven_seg_scan_driver;

    localparam int SD = 32;
    localparam int BL = 4;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] ld = 32'h0;
    logic        lv = 1'b0;
    logic        load_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seven_seg_scan_driver #(
        .SCAN_DIV(SD),
        .BLANK_CYCLES(BL),
        .AN_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rstn),
        .load_data(ld),
        .load_valid(lv),
        .load_ready(load_ready),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          fails = 0;
    int          mt = 0;
    logic [27:0] m_act = '0;
    logic [27:0] m_pend = '0;
    logic        m_pf = 1'b0;
    logic        m_rdy = 1'b0;
    logic        acc_last = 1'b0;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        int   c;
        int   ix;
        logic lit;
        logic bnd;
        logic acc;
        @(negedge clk);
        if (rstn) chk("load_ready", {31'b0, load_ready}, {31'b0, m_rdy && !m_pf});
        else      chk("load_ready_rst", {31'b0, load_ready}, 32'h0);
        c   = mt % SD;
        ix  = (mt / SD) % 4;
        lit = rstn && (c >= BL) && m_act[20+ix]
              && ((c % 16) <= int'(m_act[27:24]));
        e.an  = lit ? ~(4'b0001 << ix) : 4'hF;
        e.seg = lit ? ~hex7(m_act[4*ix +: 4]) : 7'h7F;
        e.dp  = lit ? ~m_act[16+ix] : 1'b1;
        e.ft  = rstn && (mt % FR == FR - 1);
        q.push_back(e);
        acc      = lv && rstn && m_rdy && !m_pf;
        acc_last = acc;
        bnd      = (mt > 0) && (mt % FR == 0);
        @(posedge clk);
        if (!rstn) begin
            mt = 0; m_act = '0; m_pend = '0; m_pf = 1'b0; m_rdy = 1'b0;
        end else begin
            if (bnd && m_pf) begin
                m_act = m_pend;
                m_pf  = 1'b0;
            end else if (acc) begin
                if (bnd) m_act = ld[27:0];
                else begin
                    m_pend = ld[27:0];
                    m_pf   = 1'b1;
                end
            end
            mt++;
            m_rdy = 1'b1;
        end
        #1;
        e = q.pop_front();
        chk("an", {28'b0, an}, {28'b0, e.an});
        chk("seg", {25'b0, seg}, {25'b0, e.seg});
        chk("dp", {31'b0, dp}, {31'b0, e.dp});
        chk("frame_tick", {31'b0, frame_tick}, {31'b0, e.ft});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_phase(input int p);
        for (int i = 0; i < 2 * FR; i++) begin
            if (mt % FR == p && mt > 0) break;
            step();
        end
    endtask

    task automatic offer(input logic [31:0] w, output int waited);
        logic got;
        got    = 1'b0;
        waited = 0;
        ld     = w;
        lv     = 1'b1;
        for (int i = 0; i < 3 * FR; i++) begin
            step();
            waited++;
            if (acc_last) begin
                got = 1'b1;
                break;
            end
        end
        lv = 1'b0;
        chk("offer_accepted", {31'b0, got}, 32'h1);
    endtask

    initial begin
        int w;
        int lit_cnt;
        @(posedge clk);
        #1;
        run(4);
        rstn = 1'b1;
        run(200);

        run_to_phase(40);
        offer(32'h0FF01234, w);
        run(2 * FR + 10);

        run_to_phase(40);
        offer(32'h00F0000F, w);
        chk("ready_low_after_accept", {31'b0, load_ready}, 32'h0);
        offer(32'h0F10000A, w);
        chk("second_word_held", {31'b0, w > 1}, 32'h1);
        run(2 * FR);

        run_to_phase(40);
        offer(32'h00100005, w);
        run_to_phase(1);
        lit_cnt = 0;
        for (int i = 0; i < FR; i++) begin
            step();
            if (an !== 4'hF) lit_cnt++;
        end
        chk("bright0_lit_cycles", lit_cnt, 1);

        run_to_phase(0);
        ld = 32'h0F1000C0;
        lv = 1'b1;
        step();
        lv = 1'b0;
        chk("boundary_load_no_pend", {31'b0, load_ready}, 32'h1);
        run(FR + 8);

        run_to_phase(10);
        offer(32'h0FF0ABCD, w);
        for (int i = 0; i < FR; i++) begin
            if ((mt / SD) % 4 == 2) break;
            step();
        end
        run(5);
        rstn = 1'b0;
        run(3);
        chk("rst_an_off", {28'b0, an}, 32'hF);
        rstn = 1'b1;
        run(2 * FR);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
